// File: rtl/alu_seq_pkg.sv
// -----------------------------------------------------------------------------
// alu_seq_pkg
// Shared definitions for the bit-serial ALU sequencer: the slice opcode map,
// the sequencer state encoding and a small opcode classification helper.
// -----------------------------------------------------------------------------
package alu_seq_pkg;

    // Opcode {C1,C2,C3} as understood by the external 1-bit ALU slice.
    localparam logic [2:0] OP_NOR    = 3'b000;
    localparam logic [2:0] OP_NAND   = 3'b001;
    localparam logic [2:0] OP_OR     = 3'b010;
    localparam logic [2:0] OP_AND    = 3'b011;
    localparam logic [2:0] OP_XOR    = 3'b100;
    localparam logic [2:0] OP_XNOR   = 3'b101;
    localparam logic [2:0] OP_ARITH0 = 3'b110;
    localparam logic [2:0] OP_ARITH1 = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Arithmetic opcodes propagate a carry between bits; logic opcodes do not.
    function automatic logic is_arith(input logic [2:0] op);
        return (op == OP_ARITH0) || (op == OP_ARITH1);
    endfunction

endpackage

// File: rtl/alu_seq_shreg.sv
// -----------------------------------------------------------------------------
// alu_seq_shreg
// Operand and result shift registers for the bit-serial ALU. Operands are
// loaded in parallel and shifted right one bit per step so that the current
// bit is always at position 0. The slice result bit is shifted in at the MSB,
// so after WIDTH steps the first computed bit has arrived at bit 0.
//
// Ports
//   clk     : clock, rising edge
//   rst     : synchronous active-high reset
//   load    : capture opa/opb in parallel
//   shift   : advance one bit (operands right, o_bit into result MSB)
//   opa/opb : parallel operand inputs
//   o_bit   : slice result bit for the current step
//   a_bit   : current operand A bit (LSB of the operand register)
//   b_bit   : current operand B bit
//   result  : assembled result word
// -----------------------------------------------------------------------------
module alu_seq_shreg #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    input  logic             o_bit,
    output logic             a_bit,
    output logic             b_bit,
    output logic [WIDTH-1:0] result
);

    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] res_q, res_d;

    always_comb begin
        opa_d = opa_q;
        opb_d = opb_q;
        res_d = res_q;
        if (load) begin
            opa_d = opa;
            opb_d = opb;
        end else if (shift) begin
            opa_d = opa_q >> 1;
            opb_d = opb_q >> 1;
            res_d = {o_bit, res_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            opa_q <= '0;
            opb_q <= '0;
            res_q <= '0;
        end else begin
            opa_q <= opa_d;
            opb_q <= opb_d;
            res_q <= res_d;
        end
    end

    assign a_bit  = opa_q[0];
    assign b_bit  = opb_q[0];
    assign result = res_q;

endmodule

// File: rtl/alu_serial_seq.sv
// -----------------------------------------------------------------------------
// alu_serial_seq
// Sequencer that performs a WIDTH-bit ALU operation one bit per cycle through
// an external combinational 1-bit ALU slice. A request is accepted in IDLE,
// WIDTH RUN cycles drive the slice LSB first, and the result is presented in
// DONE until the consumer takes it.
//
// Ports
//   CLK, RST            : clock (rising edge), synchronous active-high reset
//   REQ_VALID/REQ_READY : request handshake (REQ_READY high only in IDLE)
//   OPA, OPB            : WIDTH-bit operands
//   OPC                 : opcode {C1,C2,C3}
//   SUB                 : subtract select, forwarded to the slice as P
//   A, B, P, CIN,
//   C1, C2, C3          : slice inputs, zero outside RUN
//   O, COUT             : slice result and carry (combinational from inputs)
//   RSP_VALID/RSP_READY : response handshake
//   RESULT, CARRY_OUT   : result word and final carry (0 for logic opcodes)
//   ZERO, OVF           : only with ALU_SEQ_FLAGS_EN defined; result-is-zero
//                         and signed overflow (arithmetic opcodes only)
//
// Build option: define ALU_SEQ_FLAGS_EN to add the ZERO and OVF flag outputs.
// -----------------------------------------------------------------------------
module alu_serial_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             REQ_VALID,
    output logic             REQ_READY,
    input  logic [WIDTH-1:0] OPA,
    input  logic [WIDTH-1:0] OPB,
    input  logic [2:0]       OPC,
    input  logic             SUB,
    output logic             A,
    output logic             B,
    output logic             P,
    output logic             CIN,
    output logic             C1,
    output logic             C2,
    output logic             C3,
    input  logic             O,
    input  logic             COUT,
    output logic             RSP_VALID,
    input  logic             RSP_READY,
    output logic [WIDTH-1:0] RESULT,
    output logic             CARRY_OUT
`ifdef ALU_SEQ_FLAGS_EN
    ,
    output logic             ZERO,
    output logic             OVF
`endif
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [2:0]       opc_q, opc_d;
    logic             sub_q, sub_d;
    logic             carry_out_q, carry_out_d;
`ifdef ALU_SEQ_FLAGS_EN
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;
`endif

    logic load;
    logic shift;
    logic a_bit;
    logic b_bit;

    alu_seq_shreg #(
        .WIDTH (WIDTH)
    ) u_shreg (
        .clk    (CLK),
        .rst    (RST),
        .load   (load),
        .shift  (shift),
        .opa    (OPA),
        .opb    (OPB),
        .o_bit  (O),
        .a_bit  (a_bit),
        .b_bit  (b_bit),
        .result (RESULT)
    );

    // NOTE: every signal assigned in this block gets a default first, so no
    // path through the case statement can leave it unassigned (no latches).
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        opc_d       = opc_q;
        sub_d       = sub_q;
        carry_out_d = carry_out_q;
`ifdef ALU_SEQ_FLAGS_EN
        zero_d      = zero_q;
        ovf_d       = ovf_q;
`endif
        load        = 1'b0;
        shift       = 1'b0;
        A           = 1'b0;
        B           = 1'b0;
        P           = 1'b0;
        CIN         = 1'b0;
        {C1, C2, C3} = 3'b000;

        unique case (state_q)
            S_IDLE: begin
                if (REQ_VALID) begin
                    load    = 1'b1;
                    opc_d   = OPC;
                    sub_d   = SUB;
                    cnt_d   = '0;
                    // Carry-in of bit 0 is SUB: the +1 of two's-complement subtract.
                    carry_d = SUB;
                    state_d = S_RUN;
                end
            end

            S_RUN: begin
                A            = a_bit;
                B            = b_bit;
                P            = sub_q;
                CIN          = carry_q;
                {C1, C2, C3} = opc_q;
                shift        = 1'b1;
                cnt_d        = cnt_q + CNT_W'(1);
                if (is_arith(opc_q)) begin
                    carry_d = COUT;
                end
                if (cnt_q == LAST_BIT) begin
                    state_d     = S_DONE;
                    carry_out_d = is_arith(opc_q) ? COUT : 1'b0;
`ifdef ALU_SEQ_FLAGS_EN
                    // The result word only completes on this edge, so look at
                    // the value being shifted in rather than RESULT itself.
                    zero_d = ({O, RESULT[WIDTH-1:1]} == '0);
                    // carry_q is the carry into the MSB during the last bit.
                    ovf_d  = is_arith(opc_q) ? (carry_q ^ COUT) : 1'b0;
`endif
                end
            end

            S_DONE: begin
                if (RSP_READY) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state is updated only with non-blocking assignments so
    // every flop samples the pre-edge value of every other flop.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            opc_q       <= 3'b000;
            sub_q       <= 1'b0;
            carry_out_q <= 1'b0;
`ifdef ALU_SEQ_FLAGS_EN
            zero_q      <= 1'b0;
            ovf_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            opc_q       <= opc_d;
            sub_q       <= sub_d;
            carry_out_q <= carry_out_d;
`ifdef ALU_SEQ_FLAGS_EN
            zero_q      <= zero_d;
            ovf_q       <= ovf_d;
`endif
        end
    end

    assign REQ_READY = (state_q == S_IDLE);
    assign RSP_VALID = (state_q == S_DONE);
    assign CARRY_OUT = carry_out_q;
`ifdef ALU_SEQ_FLAGS_EN
    assign ZERO      = zero_q;
    assign OVF       = ovf_q;
`endif

endmodule

// File: tb/tb_alu_serial_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_serial_seq
// Self-checking bench for alu_serial_seq. Models the external 1-bit ALU slice,
// drives directed operations and scores responses against a word-level
// reference held in a scoreboard queue. Define ALU_SEQ_FLAGS_EN to also score
// the ZERO and OVF outputs.
// -----------------------------------------------------------------------------
module tb_alu_serial_seq;
    import alu_seq_pkg::*;

    localparam int W = 16;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         REQ_VALID = 1'b0;
    logic         REQ_READY;
    logic [W-1:0] OPA = '0;
    logic [W-1:0] OPB = '0;
    logic [2:0]   OPC = 3'b000;
    logic         SUB = 1'b0;
    logic         A, B, P, CIN, C1, C2, C3;
    logic         O, COUT;
    logic         RSP_VALID;
    logic         RSP_READY = 1'b0;
    logic [W-1:0] RESULT;
    logic         CARRY_OUT;
`ifdef ALU_SEQ_FLAGS_EN
    logic         ZERO, OVF;
`endif

    alu_serial_seq #(.WIDTH(W)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .REQ_VALID (REQ_VALID),
        .REQ_READY (REQ_READY),
        .OPA       (OPA),
        .OPB       (OPB),
        .OPC       (OPC),
        .SUB       (SUB),
        .A         (A),
        .B         (B),
        .P         (P),
        .CIN       (CIN),
        .C1        (C1),
        .C2        (C2),
        .C3        (C3),
        .O         (O),
        .COUT      (COUT),
        .RSP_VALID (RSP_VALID),
        .RSP_READY (RSP_READY),
        .RESULT    (RESULT),
        .CARRY_OUT (CARRY_OUT)
`ifdef ALU_SEQ_FLAGS_EN
        ,
        .ZERO      (ZERO),
        .OVF       (OVF)
`endif
    );

    always #5 CLK = ~CLK;

    // External 1-bit ALU slice.
    always_comb begin
        logic bb;
        bb   = B ^ P;
        O    = 1'b0;
        COUT = 1'b0;
        case ({C1, C2, C3})
            OP_NOR:  O = ~(A | B);
            OP_NAND: O = ~(A & B);
            OP_OR:   O = A | B;
            OP_AND:  O = A & B;
            OP_XOR:  O = A ^ B;
            OP_XNOR: O = ~(A ^ B);
            default: begin
                O    = A ^ bb ^ CIN;
                COUT = (A & bb) | (A & CIN) | (bb & CIN);
            end
        endcase
    end

    typedef struct {
        logic [W-1:0] res;
        logic         cout;
        logic         zero;
        logic         ovf;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    // Word-level reference for one complete operation.
    function automatic exp_t ref_alu(input logic [2:0] op, input logic sub,
                                     input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t         e;
        logic [W-1:0] bb;
        logic [W:0]   sum;
        e.cout = 1'b0;
        e.ovf  = 1'b0;
        case (op)
            OP_NOR:  e.res = ~(a | b);
            OP_NAND: e.res = ~(a & b);
            OP_OR:   e.res = a | b;
            OP_AND:  e.res = a & b;
            OP_XOR:  e.res = a ^ b;
            OP_XNOR: e.res = ~(a ^ b);
            default: begin
                bb     = sub ? ~b : b;
                sum    = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, sub};
                e.res  = sum[W-1:0];
                e.cout = sum[W];
                e.ovf  = (a[W-1] == bb[W-1]) && (e.res[W-1] != a[W-1]);
            end
        endcase
        e.zero = (e.res == '0);
        return e;
    endfunction

    task automatic wait_ready(input string tag);
        int cyc = 0;
        while (!REQ_READY && cyc < 50) begin
            @(posedge CLK); #1;
            cyc++;
        end
        check({tag, " req_ready"}, 32'(REQ_READY), 32'd1);
    endtask

    // One operation: accept, scramble inputs, check slice drive at bit 0,
    // measure latency, optionally hold off the consumer, then score.
    task automatic run_op(input string tag, input logic [2:0] op, input logic sub,
                          input logic [W-1:0] a, input logic [W-1:0] b, input int hold);
        int   cyc;
        exp_t e;
        wait_ready(tag);
        OPA = a; OPB = b; OPC = op; SUB = sub; REQ_VALID = 1'b1;
        @(posedge CLK); #1;
        sb.push_back(ref_alu(op, sub, a, b));
        REQ_VALID = 1'b0;
        OPA = ~a; OPB = a ^ b; OPC = op ^ 3'b001; SUB = ~sub;
        check({tag, " bit0 slice drive"}, 32'({P, CIN, C1, C2, C3, A, B}),
              32'({sub, sub, op, a[0], b[0]}));
        cyc = 1;
        while (!RSP_VALID && cyc < 100) begin
            @(posedge CLK); #1;
            cyc++;
        end
        check({tag, " latency"}, 32'(cyc), 32'(W + 1));
        if (sb.size() == 0) begin
            check({tag, " scoreboard empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check({tag, " result"}, 32'(RESULT), 32'(e.res));
            check({tag, " carry_out"}, 32'(CARRY_OUT), 32'(e.cout));
`ifdef ALU_SEQ_FLAGS_EN
            check({tag, " zero"}, 32'(ZERO), 32'(e.zero));
            check({tag, " ovf"}, 32'(OVF), 32'(e.ovf));
`endif
            check({tag, " done slice idle"}, 32'({A, B, P, CIN, C1, C2, C3}), 32'd0);
            for (int i = 0; i < hold; i++) begin
                REQ_VALID = 1'b1;
                OPA = W'($urandom);
                @(posedge CLK); #1;
                check({tag, " hold state"}, 32'({RSP_VALID, REQ_READY}), 32'b10);
                check({tag, " hold result"}, 32'(RESULT), 32'(e.res));
                check({tag, " hold carry"}, 32'(CARRY_OUT), 32'(e.cout));
            end
            REQ_VALID = 1'b0;
        end
        RSP_READY = 1'b1;
        @(posedge CLK); #1;
        RSP_READY = 1'b0;
        check({tag, " back to idle"}, 32'({RSP_VALID, REQ_READY}), 32'b01);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        check("reset handshake", 32'({REQ_READY, RSP_VALID}), 32'b10);
        check("reset result", 32'(RESULT), 32'd0);
        check("reset carry_out", 32'(CARRY_OUT), 32'd0);
        check("reset slice idle", 32'({A, B, P, CIN, C1, C2, C3}), 32'd0);
        RST = 1'b0;

        run_op("add",       OP_ARITH0, 1'b0, 16'h1234, 16'h4321, 0);
        run_op("sub",       OP_ARITH1, 1'b1, 16'h0005, 16'h0007, 0);
        run_op("add wrap",  OP_ARITH0, 1'b0, 16'hFFFF, 16'h0001, 0);
        run_op("add ovf",   OP_ARITH0, 1'b0, 16'h7FFF, 16'h0001, 0);
        run_op("and",       OP_AND,    1'b0, 16'hF0F0, 16'h3C3C, 0);
        run_op("nor",       OP_NOR,    1'b0, 16'h0F0F, 16'h00FF, 0);
        run_op("xnor",      OP_XNOR,   1'b0, 16'hAAAA, 16'hAAAA, 0);
        run_op("nand sub1", OP_NAND,   1'b1, 16'hC3A5, 16'h0FF0, 0);
        run_op("or",        OP_OR,     1'b0, 16'h1200, 16'h0034, 0);
        run_op("xor",       OP_XOR,    1'b0, 16'h5A5A, 16'hFF00, 0);
        run_op("sub borrow",OP_ARITH1, 1'b1, 16'h8000, 16'h0001, 0);
        run_op("add sub1 ", OP_ARITH0, 1'b1, 16'h0100, 16'h0001, 0);

        // Reset in the middle of RUN, during bit 8.
        wait_ready("rst mid");
        OPA = 16'hAAAA; OPB = 16'h5555; OPC = OP_ARITH0; SUB = 1'b0; REQ_VALID = 1'b1;
        @(posedge CLK); #1;
        REQ_VALID = 1'b0;
        repeat (8) begin
            @(posedge CLK); #1;
        end
        check("rst mid still running", 32'({RSP_VALID, REQ_READY}), 32'b00);
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        check("rst mid handshake", 32'({RSP_VALID, REQ_READY}), 32'b01);
        check("rst mid result", 32'(RESULT), 32'd0);
        check("rst mid carry_out", 32'(CARRY_OUT), 32'd0);
        run_op("add after rst", OP_ARITH0, 1'b0, 16'h0001, 16'h0001, 0);

        // Consumer backpressure for five DONE cycles with stray requests.
        run_op("backpressure", OP_ARITH1, 1'b1, 16'h9000, 16'h1234, 5);

        for (int i = 0; i < 4; i++) begin
            run_op("random", 3'(OP_ARITH0 | 3'(i & 1)), 1'($urandom), W'($urandom), W'($urandom), 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_serial_seq.md
ALU_SERIAL_SEQ -- requirements
Module: alu_serial_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand and result width in bits.
REQ-002 SHALL have port CLK, input, 1 bit, the single clock; all logic is clocked on its rising edge.
REQ-003 SHALL have port RST, input, 1 bit, reset; it is synchronous and active-high.
REQ-004 SHALL have port REQ_VALID, input, 1 bit, operation request valid.
REQ-005 SHALL have port REQ_READY, output, 1 bit, request accepted when high together with REQ_VALID.
REQ-006 SHALL have ports OPA and OPB, input, WIDTH bits each, the operands.
REQ-007 SHALL have port OPC, input, 3 bits, the opcode {C1,C2,C3}.
REQ-008 SHALL have port SUB, input, 1 bit, subtract select, driven to the slice as P.
REQ-009 SHALL have ports A, B, P, CIN, C1, C2 and C3, output, 1 bit each, driving the 1-bit ALU slice.
REQ-010 SHALL have ports O and COUT, input, 1 bit each, the slice result and carry, combinational from the slice inputs.
REQ-011 SHALL have port RSP_VALID, output, 1 bit, result valid.
REQ-012 SHALL have port RSP_READY, input, 1 bit, result consumed.
REQ-013 SHALL have ports RESULT, output, WIDTH bits, and CARRY_OUT, output, 1 bit.

Function
REQ-014 SHALL implement a state machine with states IDLE, RUN and DONE.
REQ-015 SHALL drive REQ_READY=1 only in IDLE.
REQ-016 SHALL, on an IDLE cycle with REQ_VALID=1: latch OPA, OPB, OPC and SUB; clear the bit counter; load the carry register with SUB; enter RUN.
REQ-017 SHALL, in RUN bit k (k=0..WIDTH-1): drive A=OPA[k], B=OPB[k], P=SUB, CIN=carry register and {C1,C2,C3}=OPC; sample O into RESULT[k] at the clock edge.
REQ-018 SHALL update the carry register from COUT each RUN cycle only for arithmetic opcodes 3'b110 and 3'b111, and hold it for logic opcodes.
REQ-019 SHALL, after bit WIDTH-1, enter DONE with RSP_VALID=1, so RSP_VALID rises WIDTH+1 cycles after the accepting edge.
REQ-020 SHALL set CARRY_OUT to the final carry register value for arithmetic opcodes and to 0 for logic opcodes.
REQ-021 SHALL hold RESULT and CARRY_OUT stable in DONE until RSP_READY=1, then go to IDLE on the next edge; there is no same-cycle turnaround.
REQ-022 SHALL ignore REQ_VALID in RUN and DONE, and SHALL ignore changes on OPA, OPB, OPC and SUB after acceptance.
REQ-023 SHALL drive A, B, P, CIN, C1, C2 and C3 to 0 in IDLE and DONE.
REQ-024 SHALL implement the opcode map 000 NOR, 001 NAND, 010 OR, 011 AND, 100 XOR, 101 XNOR, 110/111 ADD/SUB (B inverted when SUB=1).

Reset
REQ-025 SHALL, on RST=1 at any edge including mid-RUN: enter IDLE, discard the operation, and clear RSP_VALID, RESULT, CARRY_OUT, the counter and the carry register to 0, leaving REQ_READY=1 on the following cycle.

Configuration
REQ-026 SHALL, with macro ALU_SEQ_FLAGS_EN defined, add output ports ZERO (RESULT==0) and OVF (carry into the MSB XOR the final carry, arithmetic opcodes only, else 0), both valid with RSP_VALID and reset to 0.
REQ-027 SHALL, without ALU_SEQ_FLAGS_EN, omit ZERO, OVF and the MSB carry-in register entirely.

Structure
REQ-028 SHALL place the opcode constants (OP_NOR through OP_ARITH1) and the state enum in the shared package alu_seq_pkg.
REQ-029 SHALL implement operand and result handling as shift registers in one sub-module, alu_seq_shreg; counter and FSM stay in the top.

Verification
REQ-030 SHALL verify ADD: OPC=110, SUB=0, 0x1234+0x4321 -> RESULT=0x5555, CARRY_OUT=0, RSP_VALID exactly 17 cycles after accept.
REQ-031 SHALL verify SUB: OPC=111, SUB=1, 0x0005-0x0007 -> RESULT=0xFFFE, CARRY_OUT=0; also 0xFFFF+0x0001 -> 0x0000, CARRY_OUT=1, ZERO=1 (flags build).
REQ-032 SHALL verify overflow (flags build): 0x7FFF+0x0001 -> RESULT=0x8000, OVF=1, ZERO=0.
REQ-033 SHALL verify logic ops: AND 0xF0F0,0x3C3C -> 0x3030; NOR 0x0F0F,0x00FF -> 0xF000; XNOR 0xAAAA,0xAAAA -> 0xFFFF; CARRY_OUT=0 in each case.
REQ-034 SHALL verify reset mid-run: RST at bit 8 -> RSP_VALID=0 and REQ_READY=1 next cycle; a following ADD 0x0001+0x0001 -> 0x0002.
REQ-035 SHALL verify backpressure: RSP_READY low for 5 DONE cycles -> RESULT stable, REQ_READY=0, REQ_VALID pulses ignored; IDLE one cycle after RSP_READY=1.
